instr_sequencer: RTL
====================

Name: instr_sequencer

Overview:
- Program sequencer in front of instructionUnit.
- On a run request, fetches 19-bit instructions from an instruction memory at consecutive addresses and presents each one to the instruction unit with a one-cycle issue pulse.
- Waits for the matching completion (mem_done for load/store, alu_done for ALU ops), then advances.
- Replaces the free-running combinational instruction feed with a handshaked, counted program run.

Parameters:
- IMEM_AW, 10, instruction memory address width (covers 1000-entry program).
- INSTR_W, 19, instruction width: [18:15] opcode (tinyalu_pkg alu_opcode_t), [14:1] mem addr, [0] reg select.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- run  in  1  start request; sampled only in IDLE.
- prog_len  in  IMEM_AW  number of instructions to execute; captured when run is accepted.
- imem_rd  out  1  instruction memory read strobe.
- imem_addr  out  IMEM_AW  instruction memory address (= pc).
- imem_rdata  in  INSTR_W  read data, valid exactly 1 cycle after imem_rd.
- instr  out  INSTR_W  current instruction to instructionUnit; held stable from ISSUE until the next FETCH capture.
- issue  out  1  one-cycle pulse: instr is new.
- mem_done  in  1  memory interface completion.
- alu_done  in  1  ALU completion.
- busy  out  1  high in every state except IDLE.
- prog_done  out  1  one-cycle pulse at normal program completion.
- retired  out  IMEM_AW  count of completed instructions in current/last run.
- err  out  1  sticky watchdog error; constant 0 without the macro.

Behaviour:
- Reset (reset_n low at clk edge):
  - State goes to IDLE; pc=0, instr=0, retired=0, err=0.
  - imem_rd, issue, busy, prog_done = 0.
  - Reset mid-run abandons the run immediately; no prog_done.
- States: IDLE, FETCH, WAIT_RD, ISSUE, WAIT_DONE, FINISH.
- IDLE:
  - If run=1 and prog_len!=0: latch prog_len into len_q, pc=0, retired=0, clear err, go to FETCH.
  - If run=1 and prog_len==0: go to FINISH, with retired=0.
- FETCH: imem_rd=1, imem_addr=pc; go to WAIT_RD.
- WAIT_RD: imem_rd=0; capture imem_rdata into instr at this edge; go to ISSUE.
- ISSUE:
  - issue=1 for exactly this cycle.
  - Decode kind: opcode==op_load or op_store -> MEM, else ALU.
  - Go to WAIT_DONE.
- WAIT_DONE:
  - Wait for the done matching kind. The non-matching done is ignored.
  - Done pulses in the ISSUE cycle itself are ignored; only done seen in WAIT_DONE counts.
  - On matching done: retired+=1, pc+=1. Go to FINISH if pc+1==len_q, else FETCH.
- FINISH: prog_done=1 for one cycle; go to IDLE. retired holds its value until the next accepted run.
- Per-instruction latency: fetch-to-issue is 3 cycles; minimum 4 cycles per instruction when done arrives on the first WAIT_DONE cycle.
- run while busy: ignored; no queueing.
- mem_done and alu_done both high in WAIT_DONE: only the matching one counts; exactly one retire.
- pc and retired never wrap within a run, because len_q <= 2^IMEM_AW-1.

Optional Feature:
- Macro: SEQ_WATCHDOG_EN.
- Defined:
  - An 8-bit-min wait counter clears on entry to WAIT_DONE and increments each WAIT_DONE cycle.
  - If it reaches TIMEOUT_CYCLES without a matching done: err=1 (sticky until next accepted run or reset), go directly to IDLE, no prog_done, retired not incremented.
- Not defined: no counter is generated, WAIT_DONE waits indefinitely, err tied 0.

Test Plan:
- Reset check: hold reset_n=0 for 2 cycles mid-WAIT_DONE -> next cycle busy=0, issue=0, imem_rd=0, retired=0, prog_done never pulses.
- 3-instruction run: imem[0]=load addr 0x0010 regA, imem[1]=load addr 0x0011 regB, imem[2]=ALU add; prog_len=3; each done returned 2 cycles after issue -> imem_addr sequence 0,1,2; exactly 3 issue pulses; one prog_done; retired=3.
- Wrong-done filter: load issued, alu_done pulsed on WAIT_DONE cycles 1-3, then mem_done on cycle 5 -> retire only on the mem_done cycle; pc 0->1 once.
- Early done: mem_done high in the ISSUE cycle only -> ignored; sequencer stays in WAIT_DONE until a later mem_done.
- Edge cases: prog_len=0 with run=1 -> prog_done 2 cycles later, no imem_rd, retired=0; run pulsed while busy -> no restart, pc sequence unaffected.
- With SEQ_WATCHDOG_EN, TIMEOUT_CYCLES=8, no done returned -> err=1 after 8 WAIT_DONE cycles, busy=0 the next cycle, no prog_done; next run clears err.

Source files
------------

// File: rtl/instr_sequencer_if.sv
// Handshake bundle between the program sequencer, instruction memory and instruction unit.
interface instr_sequencer_if #(
    parameter int unsigned IMEM_AW = 10,
    parameter int unsigned INSTR_W = 19
);
    logic               imem_rd;
    logic [IMEM_AW-1:0] imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic [INSTR_W-1:0] instr;
    logic               issue;
    logic               mem_done;
    logic               alu_done;

    modport master (
        output imem_rd, imem_addr, instr, issue,
        input  imem_rdata, mem_done, alu_done
    );

    modport slave (
        input  imem_rd, imem_addr, instr, issue,
        output imem_rdata, mem_done, alu_done
    );
endinterface

// File: rtl/instr_sequencer.sv
// Program sequencer: fetches, issues and retires a counted run of instructions.
// Optional watchdog on the completion wait: define SEQ_WATCHDOG_EN.
module instr_sequencer #(
    parameter int unsigned IMEM_AW        = 10,
    parameter int unsigned INSTR_W        = 19,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    input  logic [IMEM_AW-1:0] prog_len,
    instr_sequencer_if.master  bus,
    output logic               busy,
    output logic               prog_done,
    output logic [IMEM_AW-1:0] retired,
    output logic               err
);
    localparam int unsigned OP_W = 4;
    // Opcode encodings matching tinyalu_pkg::alu_opcode_t.
    localparam logic [OP_W-1:0] OP_LOAD  = 4'b1000;
    localparam logic [OP_W-1:0] OP_STORE = 4'b1001;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_RD,
        ISSUE,
        WAIT_DONE,
        FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [IMEM_AW-1:0] pc_q, pc_d;
    logic [IMEM_AW-1:0] len_q, len_d;
    logic [IMEM_AW-1:0] retired_q, retired_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [OP_W-1:0]    opcode;
    logic               is_mem;
    logic               done_match;
    logic               timeout;

    assign opcode     = instr_q[INSTR_W-1 -: OP_W];
    assign is_mem     = (opcode == OP_LOAD) || (opcode == OP_STORE);
    assign done_match = is_mem ? bus.mem_done : bus.alu_done;

`ifdef SEQ_WATCHDOG_EN
    localparam int unsigned WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;

    // Last permitted WAIT_DONE cycle is the one where the count would reach the limit.
    assign timeout = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign err     = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        len_d     = len_q;
        retired_d = retired_q;
        instr_d   = instr_q;
`ifdef SEQ_WATCHDOG_EN
        wd_d      = wd_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (run) begin
                    pc_d      = '0;
                    retired_d = '0;
                    if (prog_len != '0) begin
                        len_d   = prog_len;
                        state_d = FETCH;
`ifdef SEQ_WATCHDOG_EN
                        err_d   = 1'b0;
`endif
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            FETCH:   state_d = WAIT_RD;
            WAIT_RD: begin
                instr_d = bus.imem_rdata;
                state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT_DONE;
`ifdef SEQ_WATCHDOG_EN
                wd_d    = '0;
`endif
            end
            WAIT_DONE: begin
                if (done_match) begin
                    retired_d = retired_q + IMEM_AW'(1);
                    pc_d      = pc_q + IMEM_AW'(1);
                    state_d   = ((pc_q + IMEM_AW'(1)) == len_q) ? FINISH : FETCH;
                end else if (timeout) begin
                    state_d = IDLE;
`ifdef SEQ_WATCHDOG_EN
                    err_d   = 1'b1;
`endif
                end else begin
`ifdef SEQ_WATCHDOG_EN
                    wd_d = wd_q + WD_W'(1);
`endif
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs, decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            retired_q   <= '0;
            instr_q     <= '0;
            bus.imem_rd <= 1'b0;
            bus.issue   <= 1'b0;
            busy        <= 1'b0;
            prog_done   <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            retired_q   <= retired_d;
            instr_q     <= instr_d;
            bus.imem_rd <= (state_d == FETCH);
            bus.issue   <= (state_d == ISSUE);
            busy        <= (state_d != IDLE);
            prog_done   <= (state_d == FINISH);
`ifdef SEQ_WATCHDOG_EN
            wd_q        <= wd_d;
            err_q       <= err_d;
`endif
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.instr     = instr_q;
    assign retired       = retired_q;
endmodule
